fat32_dir_scanner: RTL and testbench

FAT32_DIR_SCANNER -- requirements
Module: fat32_dir_scanner

---
 rtl/fat32_pkg.sv | 40 ++++
 rtl/fat32_entry_match.sv | 39 +++
 rtl/fat32_dir_scanner.sv | 179 +++++++++++++++++
 tb/tb_fat32_dir_scanner.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fat32_pkg.sv
// Shared constants and types for the FAT32 directory scanner.
// State encoding, entry offsets, markers and attribute masks.
package fat32_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DRAIN,
    S_REPORT
  } state_e;

  localparam int SECTOR_BYTES = 512;
  localparam logic [8:0] BYTE_LAST = 9'(SECTOR_BYTES - 1);

  localparam logic [4:0] OFF_NAME      = 5'd0;
  localparam logic [4:0] OFF_NAME_LAST = 5'd7;
  localparam logic [4:0] OFF_EXT       = 5'd8;
  localparam logic [4:0] OFF_EXT_LAST  = 5'd10;
  localparam logic [4:0] OFF_ATTR      = 5'd11;
  localparam logic [4:0] OFF_CLUS_HI0  = 5'd20;
  localparam logic [4:0] OFF_CLUS_HI1  = 5'd21;
  localparam logic [4:0] OFF_CLUS_LO0  = 5'd26;
  localparam logic [4:0] OFF_CLUS_LO1  = 5'd27;
  localparam logic [4:0] OFF_SIZE0     = 5'd28;
  localparam logic [4:0] OFF_SIZE1     = 5'd29;
  localparam logic [4:0] OFF_SIZE2     = 5'd30;
  localparam logic [4:0] OFF_SIZE3     = 5'd31;

  localparam logic [7:0] MARK_END = 8'h00;
  localparam logic [7:0] MARK_DEL = 8'hE5;

  localparam logic [7:0] ATTR_LFN = 8'h0F;
  localparam logic [7:0] ATTR_VOL = 8'h08;
  localparam logic [7:0] ATTR_DIR = 8'h10;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/fat32_entry_match.sv
// Per-byte miss detector for one 32-byte directory entry.
// Flags name/ext mismatch, deleted marker and non-file attributes.
module fat32_entry_match
  import fat32_pkg::*;
(
  input  logic [4:0]  off,
  input  logic [7:0]  byte_in,
  input  logic [63:0] name,
  input  logic [23:0] ext,
  output logic        miss
);

  logic [2:0] nidx;
  logic [1:0] eidx;
  logic [7:0] nch;
  logic [7:0] ech;

  // pick the expected character for this offset and compare
  always_comb begin
    nidx = 3'd7 - off[2:0];
    eidx = 2'd2 - off[1:0];
    nch  = name[{nidx, 3'b000} +: 8];
    ech  = ext[{eidx, 3'b000} +: 8];
    miss = 1'b0;
    unique case (1'b1)
      (off <= OFF_NAME_LAST):
        miss = (byte_in != nch) ||
               ((off == OFF_NAME) && (byte_in == MARK_DEL));
      ((off >= OFF_EXT) && (off <= OFF_EXT_LAST)):
        miss = (byte_in != ech);
      (off == OFF_ATTR):
        miss = (byte_in == ATTR_LFN) ||
               ((byte_in & (ATTR_VOL | ATTR_DIR)) != 8'h00);
      default:
        miss = 1'b0;
    endcase
  end

endmodule

// File: rtl/fat32_dir_scanner.sv
// FAT32 directory sector scanner: finds an 8.3 name in a byte stream.
// Reports start cluster and size of the first live matching file.
module fat32_dir_scanner
  import fat32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] filename,
  input  logic [23:0] extension,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  input  logic        block_done,
  output logic        busy,
  output logic        next_sector,
  output logic        done,
  output logic        found,
  output logic [31:0] first_cluster,
  output logic [31:0] file_size,
  output logic [7:0]  sector_count
);

  state_e      state_q, state_d;
  logic [63:0] name_q, name_d;
  logic [23:0] ext_q, ext_d;
  logic [8:0]  cnt_q, cnt_d;
  logic        full_q, full_d;
  logic        miss_q, miss_d;
  logic [31:0] ccl_q, ccl_d;
  logic [31:0] csz_q, csz_d;
  logic        found_q, found_d;
  logic [31:0] fc_q, fc_d;
  logic [31:0] fs_q, fs_d;
  logic [7:0]  sc_q, sc_d;
  logic        ns_q, ns_d;
  logic        done_q, done_d;

  logic [4:0]  off;
  logic        byte_miss;
  logic        miss_now;

  assign off = cnt_q[4:0];

  fat32_entry_match u_match (
    .off     (off),
    .byte_in (byte_in),
    .name    (name_q),
    .ext     (ext_q),
    .miss    (byte_miss)
  );

  // next-state, byte processing and sector bookkeeping
  always_comb begin
    state_d  = state_q;
    name_d   = name_q;
    ext_d    = ext_q;
    cnt_d    = cnt_q;
    full_d   = full_q;
    miss_d   = miss_q;
    ccl_d    = ccl_q;
    csz_d    = csz_q;
    found_d  = found_q;
    fc_d     = fc_q;
    fs_d     = fs_q;
    sc_d     = sc_q;
    ns_d     = 1'b0;
    done_d   = 1'b0;
    miss_now = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SCAN;
          name_d  = filename;
          ext_d   = extension;
          found_d = 1'b0;
          fc_d    = '0;
          fs_d    = '0;
          sc_d    = '0;
          cnt_d   = '0;
          full_d  = 1'b0;
          miss_d  = 1'b0;
        end
      end
      S_SCAN: begin
        if (byte_valid && !full_q) begin
          miss_now = ((off == OFF_NAME) ? 1'b0 : miss_q) | byte_miss;
          miss_d   = miss_now;
          cnt_d    = cnt_q + 9'd1;
          if (cnt_q == BYTE_LAST) full_d = 1'b1;
          case (off)
            OFF_CLUS_HI0: ccl_d[23:16] = byte_in;
            OFF_CLUS_HI1: ccl_d[31:24] = byte_in;
            OFF_CLUS_LO0: ccl_d[7:0]   = byte_in;
            OFF_CLUS_LO1: ccl_d[15:8]  = byte_in;
            OFF_SIZE0:    csz_d[7:0]   = byte_in;
            OFF_SIZE1:    csz_d[15:8]  = byte_in;
            OFF_SIZE2:    csz_d[23:16] = byte_in;
            OFF_SIZE3:    csz_d[31:24] = byte_in;
            default: ;
          endcase
          if ((off == OFF_NAME) && (byte_in == MARK_END)) begin
            found_d = 1'b0;
            state_d = S_DRAIN;
          end else if ((off == OFF_SIZE3) && !miss_now) begin
            fc_d    = ccl_q;
            fs_d    = {byte_in, csz_q[23:0]};
            found_d = 1'b1;
            state_d = S_DRAIN;
          end
        end
        if (block_done) begin
          sc_d = sat_inc(sc_q);
          if (state_d == S_DRAIN) begin
            state_d = S_REPORT;
          end else begin
            cnt_d  = '0;
            full_d = 1'b0;
            ns_d   = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (block_done) begin
          sc_d    = sat_inc(sc_q);
          state_d = S_REPORT;
        end
      end
      S_REPORT: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      name_q  <= '0;
      ext_q   <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      miss_q  <= 1'b0;
      ccl_q   <= '0;
      csz_q   <= '0;
      found_q <= 1'b0;
      fc_q    <= '0;
      fs_q    <= '0;
      sc_q    <= '0;
      ns_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      name_q  <= name_d;
      ext_q   <= ext_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      miss_q  <= miss_d;
      ccl_q   <= ccl_d;
      csz_q   <= csz_d;
      found_q <= found_d;
      fc_q    <= fc_d;
      fs_q    <= fs_d;
      sc_q    <= sc_d;
      ns_q    <= ns_d;
      done_q  <= done_d;
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign next_sector   = ns_q;
  assign done          = done_q;
  assign found         = found_q;
  assign first_cluster = fc_q;
  assign file_size     = fs_q;
  assign sector_count  = sc_q;

endmodule

// File: tb/tb_fat32_dir_scanner.sv
// Directed bench for fat32_dir_scanner with a directory-walk model.
// Builds sector images, predicts the lookup result and checks on done.
module tb_fat32_dir_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] filename;
  logic [23:0] extension;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        block_done;
  logic        busy;
  logic        next_sector;
  logic        done;
  logic        found;
  logic [31:0] first_cluster;
  logic [31:0] file_size;
  logic [7:0]  sector_count;

  fat32_dir_scanner dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .filename      (filename),
    .extension     (extension),
    .byte_in       (byte_in),
    .byte_valid    (byte_valid),
    .block_done    (block_done),
    .busy          (busy),
    .next_sector   (next_sector),
    .done          (done),
    .found         (found),
    .first_cluster (first_cluster),
    .file_size     (file_size),
    .sector_count  (sector_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int ns_cnt = 0;
  int cyc = 0;
  int done_cyc = 0;
  int bd_cyc = 0;
  logic prev_busy = 1'b0;

  logic        exp_found;
  logic [31:0] exp_cl;
  logic [31:0] exp_sz;
  logic [7:0]  exp_sc;
  bit          poke_start = 1'b0;
  int          extra = 0;

  logic [7:0] dir [0:1023];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (next_sector) begin
        ns_cnt++;
        chk("ns_while_busy", 32'(busy), 1);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_busy_low", 32'(busy), 0);
        chk("busy_before_done", 32'(prev_busy), 1);
        chk("done_no_ns", 32'(next_sector), 0);
        chk("found", 32'(found), 32'(exp_found));
        chk("first_cluster", first_cluster, exp_cl);
        chk("file_size", file_size, exp_sz);
        chk("sector_count", 32'(sector_count), 32'(exp_sc));
      end
    end
    prev_busy = busy;
  end

  task automatic put_entry(input int s, input int e,
                           input logic [87:0] nm, input logic [7:0] attr,
                           input logic [31:0] cl, input logic [31:0] sz);
    int b;
    b = s * 512 + e * 32;
    for (int k = 0; k < 11; k++) dir[b + k] = nm[87 - 8 * k -: 8];
    dir[b + 11] = attr;
    for (int k = 12; k < 32; k++) dir[b + k] = 8'h11;
    dir[b + 20] = cl[23:16];
    dir[b + 21] = cl[31:24];
    dir[b + 26] = cl[7:0];
    dir[b + 27] = cl[15:8];
    dir[b + 28] = sz[7:0];
    dir[b + 29] = sz[15:8];
    dir[b + 30] = sz[23:16];
    dir[b + 31] = sz[31:24];
  endtask

  task automatic fill_dir;
    logic [7:0] c1, c2;
    for (int s = 0; s < 2; s++)
      for (int e = 0; e < 16; e++) begin
        c1 = 8'(8'h41 + s);
        c2 = 8'(8'h41 + e);
        put_entry(s, e, {"FILE", c1, c2, "  ", "BIN"}, 8'h20,
                  32'(32'h100 + s * 16 + e), 32'(32'h200 + e));
      end
  endtask

  // walk entries in order; first live exact match wins, 0x00 ends
  task automatic model(input logic [87:0] nm, input int nsec);
    int b;
    bit ok;
    logic [7:0] a;
    exp_found = 1'b0;
    exp_cl = '0;
    exp_sz = '0;
    exp_sc = 8'(nsec);
    for (int s = 0; s < nsec; s++)
      for (int e = 0; e < 16; e++) begin
        b = s * 512 + e * 32;
        if (dir[b] == 8'h00) begin
          exp_sc = 8'(s + 1);
          return;
        end
        ok = 1'b1;
        for (int k = 0; k < 11; k++)
          if (dir[b + k] != nm[87 - 8 * k -: 8]) ok = 1'b0;
        if (dir[b] == 8'hE5) ok = 1'b0;
        a = dir[b + 11];
        if (a == 8'h0F || a[3] || a[4]) ok = 1'b0;
        if (ok) begin
          exp_found = 1'b1;
          exp_cl = {dir[b + 21], dir[b + 20], dir[b + 27], dir[b + 26]};
          exp_sz = {dir[b + 31], dir[b + 30], dir[b + 29], dir[b + 28]};
          exp_sc = 8'(s + 1);
          return;
        end
      end
  endtask

  task automatic send_sector(input int s, input bit coin, input int nb);
    for (int i = 0; i < nb; i++) begin
      byte_in = dir[s * 512 + i];
      byte_valid = 1'b1;
      block_done = coin && (i == 511);
      if (poke_start && s == 0 && i == 50) begin
        start = 1'b1;
        filename = "ZZZZZZZZ";
        extension = "ZZZ";
      end
      tick;
      byte_valid = 1'b0;
      block_done = 1'b0;
      start = 1'b0;
      if (i % 9 == 4) tick;
    end
    if (nb < 512) return;
    for (int x = 0; x < extra; x++) begin
      byte_in = 8'h00;
      byte_valid = 1'b1;
      tick;
      byte_valid = 1'b0;
    end
    if (!coin) begin
      tick;
      block_done = 1'b1;
      tick;
      block_done = 1'b0;
    end
    bd_cyc = cyc;
  endtask

  task automatic run_search(input logic [87:0] nm, input int nsec,
                            input bit coin);
    int d0;
    bit got;
    model(nm, nsec);
    d0 = done_cnt;
    ns_cnt = 0;
    filename = nm[87:24];
    extension = nm[23:0];
    start = 1'b1;
    tick;
    start = 1'b0;
    filename = '0;
    extension = '0;
    for (int s = 0; s < nsec; s++) begin
      send_sector(s, coin && (s == nsec - 1), 512);
      got = 1'b0;
      for (int k = 0; k < 20; k++) begin
        if (done_cnt != d0 || ns_cnt > s) begin
          got = 1'b1;
          break;
        end
        tick;
      end
      chk("sector_response", 32'(got), 1);
      if (done_cnt != d0) begin
        chk("done_latency", 32'(done_cyc - bd_cyc), 2);
        break;
      end
    end
    chk("done_count", 32'(done_cnt - d0), 1);
    chk("ns_pulses", 32'(ns_cnt), 32'(int'(exp_sc) - 1));
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    rst = 1'b1;
    start = 1'b0;
    byte_valid = 1'b0;
    block_done = 1'b0;
    byte_in = '0;
    filename = '0;
    extension = '0;
    repeat (3) tick;
    rst = 1'b0;
    tick;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ns", 32'(next_sector), 0);
    chk("rst_found", 32'(found), 0);
    chk("rst_cluster", first_cluster, 0);
    chk("rst_size", file_size, 0);
    chk("rst_sc", 32'(sector_count), 0);

    byte_valid = 1'b1;
    block_done = 1'b1;
    tick;
    byte_valid = 1'b0;
    block_done = 1'b0;
    tick;
    tick;
    chk("idle_busy", 32'(busy), 0);
    chk("idle_sc", 32'(sector_count), 0);
    chk("idle_ns", 32'(ns_cnt), 0);

    fill_dir;
    put_entry(0, 2, "README  TXT", 8'h20, 32'h5, 32'h400);
    model("README  TXT", 1);
    chk("pin_t1_cl", exp_cl, 32'h5);
    chk("pin_t1_sz", exp_sz, 32'd1024);
    chk("pin_t1_sc", 32'(exp_sc), 1);
    run_search("README  TXT", 1, 1'b0);

    fill_dir;
    dir[0] = 8'h00;
    model("MISSING DAT", 1);
    chk("pin_t2_found", 32'(exp_found), 0);
    chk("pin_t2_sc", 32'(exp_sc), 1);
    run_search("MISSING DAT", 1, 1'b0);

    fill_dir;
    put_entry(1, 15, "DATA    BIN", 8'h21, 32'h12345678, 32'h0000ABCD);
    model("DATA    BIN", 2);
    chk("pin_t3_sc", 32'(exp_sc), 2);
    extra = 3;
    poke_start = 1'b1;
    run_search("DATA    BIN", 2, 1'b0);
    extra = 0;
    poke_start = 1'b0;

    fill_dir;
    put_entry(0, 0, "REPORT  DOC", 8'h10, 32'hDEAD0001, 32'h1);
    put_entry(0, 1, {8'hE5, "EPORT  DOC"}, 8'h20, 32'hDEAD0002, 32'h2);
    put_entry(0, 2, "REPORT  DOC", 8'h0F, 32'hDEAD0003, 32'h3);
    put_entry(0, 3, "REPORT  DOC", 8'h08, 32'hDEAD0004, 32'h4);
    put_entry(0, 4, "report  doc", 8'h20, 32'hDEAD0005, 32'h5);
    put_entry(0, 5, "REPORT  DOC", 8'h20, 32'h00ABCDEF, 32'h1000);
    model("REPORT  DOC", 1);
    chk("pin_t4_cl", exp_cl, 32'h00ABCDEF);
    chk("pin_t4_sz", exp_sz, 32'h1000);
    run_search("REPORT  DOC", 1, 1'b0);

    fill_dir;
    put_entry(0, 3, "README  TXT", 8'h20, 32'h7, 32'd99);
    d0 = done_cnt;
    filename = "README  ";
    extension = "TXT";
    start = 1'b1;
    tick;
    start = 1'b0;
    send_sector(0, 1'b0, 100);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tick;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_found", 32'(found), 0);
    chk("midrst_sc", 32'(sector_count), 0);
    repeat (5) tick;
    chk("midrst_no_done", 32'(done_cnt - d0), 0);
    run_search("README  TXT", 1, 1'b0);

    fill_dir;
    put_entry(0, 15, "LAST    ONE", 8'h20, 32'hCAFE0001, 32'h200);
    model("LAST    ONE", 1);
    chk("pin_t6_found", 32'(exp_found), 1);
    chk("pin_t6_sc", 32'(exp_sc), 1);
    run_search("LAST    ONE", 1, 1'b1);
    repeat (3) tick;
    chk("hold_found", 32'(found), 1);
    chk("hold_cluster", first_cluster, 32'hCAFE0001);
    chk("hold_size", file_size, 32'h200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
